// File: rtl/csr_access_ctrl.sv
// csr_access_ctrl: Zicsr read-modify-write sequencer between execute and the CSR file
// Walks each request through IDLE -> READ -> WRITE -> RESP against a single-port CSR file.
module csr_access_ctrl #(
   parameter int WORD_SIZE = 32
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_req_valid,
   output logic                 o_req_ready,
   input  logic [11:0]          i_addr,
   input  logic [2:0]           i_funct3,
   input  logic [WORD_SIZE-1:0] i_rs1_data,
   input  logic [4:0]           i_zimm,
   input  logic                 i_rs1_zero,
   input  logic                 i_rd_zero,
   output logic [11:0]          o_csr_addr,
   output logic                 o_csr_re,
   input  logic [WORD_SIZE-1:0] i_csr_rdata,
   input  logic                 i_csr_miss,
   output logic                 o_csr_we,
   output logic [WORD_SIZE-1:0] o_csr_wdata,
   output logic                 o_rsp_valid,
   input  logic                 i_rsp_ready,
   output logic [WORD_SIZE-1:0] o_rsp_rd,
   output logic                 o_rsp_illegal
);
   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
   state_t state;
   logic [WORD_SIZE-1:0] src_q, rd_q, new_q, src_in, new_rd;
   logic [1:0] op_q;
   logic [11:0] addr_q;
   logic ill_q, wr_need_q, rd_need_q;
   logic rd_need_in, wr_need_in, ill_f3, ro, rd_fault;
   always_comb begin
      src_in     = i_funct3[2] ? {{(WORD_SIZE-5){1'b0}}, i_zimm} : i_rs1_data;
      rd_need_in = !(i_funct3[1:0] == 2'b01 && i_rd_zero);
      wr_need_in = (i_funct3[1:0] == 2'b01) || !(i_funct3[2] ? i_zimm == 5'd0 : i_rs1_zero);
      ill_f3     = i_funct3[1:0] == 2'b00;
      ro         = addr_q[11:10] == 2'b11;
      rd_fault   = i_csr_miss || (wr_need_q && ro);
      new_rd     = op_q == 2'b01 ? src_q :
                   op_q == 2'b10 ? (i_csr_rdata | src_q) : (i_csr_rdata & ~src_q);
   end
   assign o_req_ready   = state == IDLE;
   assign o_csr_re      = state == READ;
   // The write strobe is suppressed combinationally so an illegal write never reaches the file
   assign o_csr_we      = state == WRITE && !i_csr_miss && !ro;
   assign o_csr_addr    = addr_q;
   assign o_csr_wdata   = new_q;
   assign o_rsp_valid   = state == RESP;
   assign o_rsp_rd      = (ill_q || !rd_need_q) ? '0 : rd_q;
   assign o_rsp_illegal = ill_q;
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state     <= IDLE;
         src_q     <= '0;
         rd_q      <= '0;
         new_q     <= '0;
         op_q      <= '0;
         addr_q    <= '0;
         ill_q     <= 1'b0;
         wr_need_q <= 1'b0;
         rd_need_q <= 1'b0;
      end else begin
         case (state)
            IDLE: if (i_req_valid) begin
               src_q     <= src_in;
               new_q     <= src_in;
               op_q      <= i_funct3[1:0];
               addr_q    <= i_addr;
               rd_need_q <= rd_need_in;
               wr_need_q <= wr_need_in;
               ill_q     <= ill_f3;
               state     <= ill_f3 ? RESP : rd_need_in ? READ : WRITE;
            end
            READ: begin
               rd_q  <= i_csr_rdata;
               new_q <= new_rd;
               ill_q <= rd_fault;
               state <= (rd_fault || !wr_need_q) ? RESP : WRITE;
            end
            WRITE: begin
               ill_q <= i_csr_miss || ro;
               state <= RESP;
            end
            RESP: if (i_rsp_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_csr_access_ctrl.sv
// tb_csr_access_ctrl: directed plus random Zicsr requests against a CSR file model,
// each checked against an architectural prediction of result, latency and write effect.
module tb_csr_access_ctrl;
   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_req_valid = 1'b0;
   logic        o_req_ready;
   logic [11:0] i_addr = '0;
   logic [2:0]  i_funct3 = '0;
   logic [31:0] i_rs1_data = '0;
   logic [4:0]  i_zimm = '0;
   logic        i_rs1_zero = 1'b0;
   logic        i_rd_zero = 1'b0;
   logic [11:0] o_csr_addr;
   logic        o_csr_re;
   logic [31:0] i_csr_rdata;
   logic        i_csr_miss;
   logic        o_csr_we;
   logic [31:0] o_csr_wdata;
   logic        o_rsp_valid;
   logic        i_rsp_ready = 1'b0;
   logic [31:0] o_rsp_rd;
   logic        o_rsp_illegal;

   int errors = 0;
   int checks = 0;
   int re_cnt = 0;
   int we_cnt = 0;
   logic [31:0] env_mem [0:4095];
   logic [31:0] ref_mem [0:4095];
   logic        poke_en = 1'b0;
   logic [11:0] poke_addr = '0;
   logic [31:0] poke_data = '0;
   logic [11:0] addr_list [0:7];

   csr_access_ctrl #(.WORD_SIZE(32)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
      .i_addr(i_addr), .i_funct3(i_funct3), .i_rs1_data(i_rs1_data), .i_zimm(i_zimm),
      .i_rs1_zero(i_rs1_zero), .i_rd_zero(i_rd_zero), .o_csr_addr(o_csr_addr),
      .o_csr_re(o_csr_re), .i_csr_rdata(i_csr_rdata), .i_csr_miss(i_csr_miss),
      .o_csr_we(o_csr_we), .o_csr_wdata(o_csr_wdata), .o_rsp_valid(o_rsp_valid),
      .i_rsp_ready(i_rsp_ready), .o_rsp_rd(o_rsp_rd), .o_rsp_illegal(o_rsp_illegal)
   );

   always #5 i_clk = ~i_clk;

   // CSR file: addresses ending in 0xEE are unimplemented
   assign i_csr_rdata = env_mem[o_csr_addr];
   assign i_csr_miss  = o_csr_addr[7:0] == 8'hEE;

   always @(posedge i_clk) begin
      if (poke_en) env_mem[poke_addr] <= poke_data;
      else if (o_csr_we) begin
         env_mem[o_csr_addr] <= o_csr_wdata;
         we_cnt <= we_cnt + 1;
      end
      if (o_csr_re) re_cnt <= re_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic poke(input logic [11:0] a, input logic [31:0] d);
      poke_en = 1'b1; poke_addr = a; poke_data = d;
      @(negedge i_clk);
      poke_en = 1'b0;
      ref_mem[a] = d;
   endtask

   task automatic do_req(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] rs1,
                         input logic [4:0] zimm, input logic rs1z, input logic rdz,
                         input int hold, input string tag);
      logic [1:0] op;
      logic [31:0] src, old, nv, erd;
      logic rdn, wrn, ill;
      int lat, cyc, re0, we0;
      op  = f3[1:0];
      src = f3[2] ? {27'd0, zimm} : rs1;
      old = ref_mem[a];
      rdn = !(op == 2'b01 && rdz);
      wrn = (op == 2'b01) || !(f3[2] ? zimm == 5'd0 : rs1z);
      ill = op == 2'b00 || a[7:0] == 8'hEE || (wrn && a[11:10] == 2'b11);
      lat = op == 2'b00 ? 1 : (rdn && wrn && !ill) ? 3 : 2;
      nv  = op == 2'b01 ? src : op == 2'b10 ? (old | src) : (old & ~src);
      erd = (ill || !rdn) ? 32'd0 : old;
      if (!ill && wrn) ref_mem[a] = nv;
      re0 = re_cnt; we0 = we_cnt;
      chk({tag, " req_ready"}, {31'd0, o_req_ready}, 32'd1);
      i_req_valid = 1'b1; i_funct3 = f3; i_addr = a; i_rs1_data = rs1;
      i_zimm = zimm; i_rs1_zero = rs1z; i_rd_zero = rdz;
      @(negedge i_clk);
      i_req_valid = 1'b0;
      cyc = 1;
      while (!o_rsp_valid && cyc < 8) begin
         @(negedge i_clk);
         cyc++;
      end
      chk({tag, " latency"}, cyc, lat);
      for (int k = 0; k < hold; k++) begin
         chk({tag, " hold rd"}, o_rsp_rd, erd);
         chk({tag, " hold ill"}, {31'd0, o_rsp_illegal}, {31'd0, ill});
         chk({tag, " hold busy"}, {30'd0, o_rsp_valid, o_req_ready}, 32'd2);
         @(negedge i_clk);
      end
      chk({tag, " rsp_rd"}, o_rsp_rd, erd);
      chk({tag, " illegal"}, {31'd0, o_rsp_illegal}, {31'd0, ill});
      i_rsp_ready = 1'b1;
      @(negedge i_clk);
      i_rsp_ready = 1'b0;
      chk({tag, " idle after"}, {30'd0, o_rsp_valid, o_req_ready}, 32'd1);
      chk({tag, " reads"}, re_cnt - re0, (op != 2'b00 && rdn) ? 1 : 0);
      chk({tag, " writes"}, we_cnt - we0, (!ill && wrn) ? 1 : 0);
      chk({tag, " csr value"}, env_mem[a], ref_mem[a]);
   endtask

   initial begin
      int we0;
      addr_list = '{12'h340, 12'h300, 12'h305, 12'hF11, 12'hC00, 12'h3EE, 12'h7C0, 12'h341};
      #2;
      chk("reset ready", {31'd0, o_req_ready}, 32'd1);
      chk("reset strobes", {30'd0, o_csr_re, o_csr_we}, 32'd0);
      chk("reset rsp", {30'd0, o_rsp_valid, o_rsp_illegal}, 32'd0);
      chk("reset rsp_rd", o_rsp_rd, 32'd0);
      chk("reset addr", {20'd0, o_csr_addr}, 32'd0);
      chk("reset wdata", o_csr_wdata, 32'd0);
      @(negedge i_clk);
      @(negedge i_clk);
      i_rst = 1'b0;
      for (int i = 0; i < 8; i++) poke(addr_list[i], $urandom);

      poke(12'h340, 32'h12345678);
      do_req(3'b001, 12'h340, 32'hDEADBEEF, 5'd0, 1'b0, 1'b0, 0, "csrrw");
      chk("csrrw wdata", env_mem[12'h340], 32'hDEADBEEF);
      poke(12'h300, 32'h0000F0F0);
      do_req(3'b010, 12'h300, 32'h00000F00, 5'd0, 1'b0, 1'b0, 0, "csrrs");
      chk("csrrs wdata", env_mem[12'h300], 32'h0000FFF0);
      poke(12'h300, 32'h0000F0F0);
      do_req(3'b011, 12'h300, 32'h000000F0, 5'd0, 1'b0, 1'b0, 0, "csrrc");
      chk("csrrc wdata", env_mem[12'h300], 32'h0000F000);
      poke(12'h300, 32'h0000F0F0);
      do_req(3'b110, 12'h300, 32'hFFFFFFFF, 5'd0, 1'b0, 1'b0, 0, "csrrsi0");
      do_req(3'b001, 12'hF11, 32'h11111111, 5'd0, 1'b0, 1'b0, 0, "ro rw");
      do_req(3'b010, 12'hF11, 32'h0, 5'd0, 1'b1, 1'b0, 0, "ro read");
      do_req(3'b001, 12'hF11, 32'h22222222, 5'd0, 1'b0, 1'b1, 0, "ro rw x0");
      do_req(3'b001, 12'h305, 32'hA5A5A5A5, 5'd0, 1'b0, 1'b1, 0, "rw x0");
      do_req(3'b100, 12'h340, 32'h1, 5'd3, 1'b0, 1'b0, 0, "f3 100");
      do_req(3'b000, 12'h340, 32'h1, 5'd3, 1'b0, 1'b0, 0, "f3 000");
      do_req(3'b010, 12'h3EE, 32'h00FF00FF, 5'd0, 1'b0, 1'b0, 0, "miss");
      do_req(3'b101, 12'h3EE, 32'h0, 5'd7, 1'b0, 1'b1, 0, "miss x0");
      do_req(3'b011, 12'h340, 32'h0000FFFF, 5'd0, 1'b0, 1'b0, 5, "backpressure");
      do_req(3'b111, 12'h340, 32'h0, 5'd31, 1'b0, 1'b0, 0, "back2back");

      // reset while the request sits in READ
      we0 = we_cnt;
      i_req_valid = 1'b1; i_funct3 = 3'b001; i_addr = 12'h341; i_rs1_data = 32'hCAFEF00D;
      i_rs1_zero = 1'b0; i_rd_zero = 1'b0;
      @(negedge i_clk);
      i_req_valid = 1'b0;
      chk("rst mid re", {31'd0, o_csr_re}, 32'd1);
      i_rst = 1'b1;
      #1;
      chk("rst mid state", {28'd0, o_req_ready, o_csr_re, o_csr_we, o_rsp_valid}, 32'd8);
      chk("rst mid addr", {20'd0, o_csr_addr}, 32'd0);
      @(negedge i_clk);
      i_rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk("rst no rsp", {31'd0, o_rsp_valid}, 32'd0);
         @(negedge i_clk);
      end
      chk("rst no write", we_cnt - we0, 32'd0);
      chk("rst csr kept", env_mem[12'h341], ref_mem[12'h341]);

      for (int n = 0; n < 40; n++)
         do_req(3'($urandom_range(0, 7)), addr_list[$urandom_range(0, 7)], $urandom,
                ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), 1'($urandom), 1'($urandom),
                $urandom_range(0, 2), "random");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
